fifo_stream: RTL and testbench

// Single-clock, first-word-fall-through FIFO with valid/ready handshakes on both sides.

---
 rtl/fifo_stream.sv | 164 ++++++++++++++++
 tb/tb_fifo_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream.sv
// ---------------------------------------------------------------------------
// fifo_stream
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on
// both sides. Any DEPTH >= 2 is supported, and the capacity is exactly DEPTH
// entries. It provides programmable almost-full and almost-empty flags, a
// synchronous flush, an optional empty-bypass path and a sticky
// overflow-attempt flag. Storage is an internal register array.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active-low
//   flush        in   synchronous clear of all contents (highest priority)
//   s_valid      in   write side: data valid
//   s_ready      out  write side: FIFO can accept
//   s_data       in   write payload
//   m_valid      out  read side: head entry valid
//   m_ready      in   read side: consumer accepts
//   m_data       out  head entry (or s_data when bypassing)
//   entries      out  current occupancy, 0..DEPTH
//   full         out  entries == DEPTH
//   empty        out  entries == 0
//   almost_full  out  entries >= AFULL_THRESH
//   almost_empty out  entries <= AEMPTY_THRESH
//   overflow     out  sticky: a write was offered while s_ready was low
// ---------------------------------------------------------------------------
module fifo_stream #(
   parameter int DEPTH         = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2,
   parameter int BYPASS        = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic [$clog2(DEPTH+1)-1:0]   entries,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic          BYP_EN   = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] entries_q, entries_d;
   logic          overflow_q, overflow_d;

   logic empty_int;
   logic full_int;
   logic bypass_act;
   logic push;
   logic pop;
   logic bypass_xfer;
   logic wr_en;
   logic rd_en;

   // Flags decode the registered count only, so they never glitch on inputs.
   assign empty_int    = (entries_q == '0);
   assign full_int     = (entries_q == DEPTH_C);
   assign entries      = entries_q;
   assign full         = full_int;
   assign empty        = empty_int;
   assign almost_full  = (entries_q >= AFULL_C);
   assign almost_empty = (entries_q <= AEMPTY_C);
   assign overflow     = overflow_q;

   // s_ready deliberately ignores m_ready: a full FIFO refuses data even
   // in a cycle where it is also being popped.
   assign s_ready    = rst_n & ~full_int & ~flush;
   assign bypass_act = BYP_EN & empty_int & s_valid;
   assign m_valid    = rst_n & ~flush & (~empty_int | bypass_act);

   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // A bypassed word that is accepted in the same cycle never touches storage.
   assign bypass_xfer = bypass_act & pop;
   assign wr_en       = push & ~bypass_xfer;
   assign rd_en       = pop & ~bypass_xfer;

   always_comb begin
      m_data = '0;
      if (rst_n) begin
         if (bypass_act) begin
            m_data = s_data;
         end else begin
            m_data = mem_q[rd_ptr_q];
         end
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      entries_d  = entries_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         entries_d  = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         end
         // Saturating guards: unreachable through the handshakes, but keep
         // the count inside 0..DEPTH regardless.
         if (wr_en && !rd_en && (entries_q != DEPTH_C)) begin
            entries_d = entries_q + 1'b1;
         end else if (rd_en && !wr_en && (entries_q != '0)) begin
            entries_d = entries_q - 1'b1;
         end
         if (s_valid && !s_ready) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         entries_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         entries_q  <= entries_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   a_entries_range : assert property (@(posedge clk) disable iff (!rst_n)
      entries_q <= DEPTH_C);

endmodule

// File: tb/tb_fifo_stream.sv
// Two instances share the stimulus: d0 (DEPTH=5, no bypass) and d1
// (DEPTH=5, bypass). Each is checked every cycle against a queue model.
module tb_fifo_stream;

   localparam int DEPTH = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       s_valid = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] s_data = 8'h00;

   logic       sr [2];
   logic       mv [2];
   logic [7:0] md [2];
   logic [2:0] en [2];
   logic       fu [2];
   logic       em [2];
   logic       af [2];
   logic       ae [2];
   logic       ov [2];

   int checks = 0;
   int failures = 0;

   logic [7:0] mq [2][$];
   bit         ovf_m [2];
   bit         pend_push [2];
   bit         pend_pop [2];
   bit         pend_ovf [2];
   logic [7:0] pend_data;
   bit         pend_flush;

   always #5 clk = ~clk;

   fifo_stream #(.DEPTH(DEPTH), .DATA_WIDTH(8), .AFULL_THRESH(4),
                 .AEMPTY_THRESH(1), .BYPASS(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_valid(s_valid), .s_ready(sr[0]), .s_data(s_data),
      .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]),
      .entries(en[0]), .full(fu[0]), .empty(em[0]),
      .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]));

   fifo_stream #(.DEPTH(DEPTH), .DATA_WIDTH(8), .AFULL_THRESH(4),
                 .AEMPTY_THRESH(1), .BYPASS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_valid(s_valid), .s_ready(sr[1]), .s_data(s_data),
      .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]),
      .entries(en[1]), .full(fu[1]), .empty(em[1]),
      .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]));

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs come from occupancy of the model queue and the inputs.
   task automatic eval_dut(input int id);
      int  n;
      bit  byp;
      bit  e_sr;
      bit  e_mv;
      n    = mq[id].size();
      byp  = (id == 1);
      e_sr = (n < DEPTH) && !flush;
      e_mv = !flush && ((n > 0) || (byp && s_valid));
      check_val($sformatf("d%0d_entries", id), 32'(en[id]), n);
      check_val($sformatf("d%0d_full", id), 32'(fu[id]), 32'(n == DEPTH));
      check_val($sformatf("d%0d_empty", id), 32'(em[id]), 32'(n == 0));
      check_val($sformatf("d%0d_afull", id), 32'(af[id]), 32'(n >= 4));
      check_val($sformatf("d%0d_aempty", id), 32'(ae[id]), 32'(n <= 1));
      check_val($sformatf("d%0d_s_ready", id), 32'(sr[id]), 32'(e_sr));
      check_val($sformatf("d%0d_m_valid", id), 32'(mv[id]), 32'(e_mv));
      check_val($sformatf("d%0d_overflow", id), 32'(ov[id]), 32'(ovf_m[id]));
      if (e_mv) begin
         check_val($sformatf("d%0d_m_data", id), 32'(md[id]),
                   32'((n > 0) ? mq[id][0] : s_data));
      end
      pend_push[id] = s_valid && e_sr;
      pend_pop[id]  = e_mv && m_ready;
      pend_ovf[id]  = s_valid && !e_sr && !flush;
   endtask

   task automatic apply_model(input int id);
      if (pend_flush) begin
         mq[id].delete();
         ovf_m[id] = 1'b0;
      end else begin
         if (!(pend_push[id] && pend_pop[id] && mq[id].size() == 0)) begin
            if (pend_pop[id]) void'(mq[id].pop_front());
            if (pend_push[id]) mq[id].push_back(pend_data);
         end
         if (pend_ovf[id]) ovf_m[id] = 1'b1;
      end
   endtask

   task automatic step(input logic sv, input logic [7:0] sd,
                       input logic mr, input logic fl);
      @(negedge clk);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush   = fl;
      #2;
      pend_data  = sd;
      pend_flush = fl;
      for (int i = 0; i < 2; i++) eval_dut(i);
      @(posedge clk);
      for (int i = 0; i < 2; i++) apply_model(i);
      #1;
   endtask

   // Reset asserted between edges with traffic offered; outputs must drop at once.
   task automatic mid_reset();
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h3C;
      m_ready = 1'b1;
      flush   = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("rst%0d_s_ready", i), 32'(sr[i]), 0);
         check_val($sformatf("rst%0d_m_valid", i), 32'(mv[i]), 0);
         check_val($sformatf("rst%0d_m_data", i), 32'(md[i]), 0);
         check_val($sformatf("rst%0d_entries", i), 32'(en[i]), 0);
         mq[i].delete();
         ovf_m[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_val("rst1_m_valid_hold", 32'(mv[1]), 0);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("rel%0d_s_ready", i), 32'(sr[i]), 1);
         check_val($sformatf("rel%0d_empty", i), 32'(em[i]), 1);
         check_val($sformatf("rel%0d_aempty", i), 32'(ae[i]), 1);
         check_val($sformatf("rel%0d_full", i), 32'(fu[i]), 0);
         check_val($sformatf("rel%0d_afull", i), 32'(af[i]), 0);
         check_val($sformatf("rel%0d_overflow", i), 32'(ov[i]), 0);
      end
   endtask

   initial begin
      int pv;
      int pr;
      #2;
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("init%0d_s_ready", i), 32'(sr[i]), 0);
         check_val($sformatf("init%0d_m_valid", i), 32'(mv[i]), 0);
      end
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // In-order fill to full, then drain
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h11 + k), 1'b0, 1'b0);
      check_val("t1_full", 32'(fu[0]), 1);
      check_val("t1_s_ready", 32'(sr[0]), 0);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("t1_empty", 32'(em[0]), 1);

      // Pointer wrap on a non-power-of-two depth
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 8'(k + 1), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
      check_val("t2_entries", 32'(en[0]), 5);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Steady push+pop at two entries
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h21, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      check_val("t3_entries", 32'(en[0]), 2);

      // Bypass from empty
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      check_val("t4_byp_entries", 32'(en[1]), 0);
      check_val("t4_nobyp_entries", 32'(en[0]), 1);

      // Threshold walk and overflow until flush
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      check_val("t5_overflow_set", 32'(ov[0]), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("t5_overflow_sticky", 32'(ov[0]), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_val("t5_overflow_clr", 32'(ov[0]), 0);

      // Flush with the consumer ready, then reset mid-burst
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check_val("t6_entries", 32'(en[0]), 0);
      for (int k = 0; k < 2; k++) step(1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
      mid_reset();

      // Random traffic with shifting push/pop bias
      pv = 50;
      pr = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            pv = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
         end
         if (c == 1500) mid_reset();
         step(1'($urandom_range(0, 99) < pv), 8'($urandom),
              1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 99) < 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
